// File: rtl/terrain_pkg.sv
// rtl/terrain_pkg.sv - shared state encoding and LFSR constants for the terrain generator
package terrain_pkg;

  typedef enum logic {
    ST_FLOOR = 1'b0,
    ST_GAP   = 1'b1
  } seg_state_e;

  localparam logic [15:0] LFSR_MASK      = 16'hB400;
  localparam logic [15:0] ZERO_SEED_REPL = 16'h0001;

  // An all-zero state would lock the LFSR, so it is never allowed in.
  function automatic logic [15:0] guard_seed(input logic [15:0] s);
    return (s == 16'h0000) ? ZERO_SEED_REPL : s;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_MASK : 16'h0000);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - 16-bit Galois LFSR with step and seed load (load wins)
import terrain_pkg::*;

module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        step_i,
  input  logic        load_i,
  input  logic [15:0] load_val_i,
  output logic [15:0] state_o
);

  logic [15:0] state_d, state_q;

  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = guard_seed(load_val_i);
    end else if (step_i) begin
      state_d = lfsr_next(state_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= guard_seed(SEED);
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/terrain_line_gen.sv
// rtl/terrain_line_gen.sv - scrolling floor/gap line with segment FSM driven by an LFSR
import terrain_pkg::*;

module terrain_line_gen #(
  parameter int          WIDTH   = 640,
  parameter int          SEG_LEN = 80,
  parameter int          MIN_RUN = 2,
  parameter int          MAX_GAP = 2,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             en_i,
  input  logic [7:0]       density_i,
  input  logic             seed_load_i,
  input  logic [15:0]      seed_i,
  output logic [WIDTH-1:0] line_o,
  output logic             seg_done_o,
  output logic             gap_o
);

  localparam int PIX_W = $clog2(SEG_LEN);
  localparam int RUN_W = $clog2(MIN_RUN + 1);
  localparam int GAP_W = $clog2(MAX_GAP + 1);

  logic [WIDTH-1:0] line_d, line_q;
  logic [PIX_W-1:0] pix_cnt_d, pix_cnt_q;
  logic [RUN_W-1:0] run_cnt_d, run_cnt_q;
  logic [GAP_W-1:0] gap_cnt_d, gap_cnt_q;
  logic             seg_done_d, seg_done_q;
  seg_state_e       state_d, state_q;

  logic [15:0] lfsr_state;
  logic [7:0]  rand_byte;
  logic        pix_last;
  logic        draw_gap;
  logic [RUN_W:0] run_inc;

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .step_i     (en_i),
    .load_i     (seed_load_i),
    .load_val_i (seed_i),
    .state_o    (lfsr_state)
  );

  assign rand_byte = lfsr_state[7:0];
  assign pix_last  = (pix_cnt_q == PIX_W'(SEG_LEN - 1));
  assign draw_gap  = (rand_byte < density_i);
  assign run_inc   = {1'b0, run_cnt_q} + (RUN_W + 1)'(1);

  always_comb begin
    line_d     = line_q;
    pix_cnt_d  = pix_cnt_q;
    run_cnt_d  = run_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    state_d    = state_q;
    seg_done_d = 1'b0;
    if (en_i) begin
      // The boundary shift still carries the old segment's last pixel.
      line_d     = {state_q == ST_FLOOR, line_q[WIDTH-1:1]};
      pix_cnt_d  = pix_last ? '0 : pix_cnt_q + PIX_W'(1);
      seg_done_d = pix_last;
      if (pix_last) begin
        case (state_q)
          ST_FLOOR: begin
            run_cnt_d = (run_inc > (RUN_W + 1)'(MIN_RUN)) ? RUN_W'(MIN_RUN)
                                                          : run_inc[RUN_W-1:0];
            if (run_inc >= (RUN_W + 1)'(MIN_RUN) && draw_gap) begin
              state_d   = ST_GAP;
              gap_cnt_d = GAP_W'(1);
              run_cnt_d = '0;
            end
          end
          default: begin
            if (gap_cnt_q < GAP_W'(MAX_GAP) && draw_gap) begin
              gap_cnt_d = gap_cnt_q + GAP_W'(1);
            end else begin
              state_d   = ST_FLOOR;
              run_cnt_d = '0;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      line_q     <= '1;
      pix_cnt_q  <= '0;
      run_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      state_q    <= ST_FLOOR;
      seg_done_q <= 1'b0;
    end else begin
      line_q     <= line_d;
      pix_cnt_q  <= pix_cnt_d;
      run_cnt_q  <= run_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      state_q    <= state_d;
      seg_done_q <= seg_done_d;
    end
  end

  assign line_o     = line_q;
  assign seg_done_o = seg_done_q;
  assign gap_o      = (state_q == ST_GAP);

endmodule
